mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_mem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Byte-addressable word memory behind a valid/ready request port. Unaligned
// accesses that straddle a word boundary are split into two storage beats.
package isa_types;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    write_byte = 2'd0,
    write_half = 2'd1,
    write_word = 2'd2
  } write_width_t;
endpackage

module mem_responder
  import isa_types::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic            CLOCK_50,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  write_width_t    req_width,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error
);

  localparam int         AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  // Request decode, evaluated on the accept edge only.
  logic        accept;
  logic [2:0]  acc_span;
  logic [3:0]  acc_lanes;
  logic [7:0]  acc_be;
  logic [63:0] acc_data;
  logic [32:0] acc_last;
  logic        acc_err;
  logic        acc_split;

  // Captured request.
  logic          r_write;
  logic          r_err;
  logic          r_split;
  logic [1:0]    r_off;
  logic [7:0]    r_be;
  logic [63:0]   r_data;
  logic [31:0]   r_rmask;
  logic [AW-1:0] r_idx0;
  logic [AW-1:0] r_idx1;

  logic [31:0] cap_lo;
  logic [31:0] mem_lo;
  logic [31:0] mem_hi;
  logic [31:0] rd_single;
  logic [63:0] rd_pair;
  logic        mem_we0;
  logic        mem_we1;

  assign accept = req_valid && req_ready;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    acc_span  = 3'd3;
    acc_lanes = 4'b1111;
    case (req_width)
      write_byte: begin
        acc_span  = 3'd0;
        acc_lanes = 4'b0001;
      end
      write_half: begin
        acc_span  = 3'd1;
        acc_lanes = 4'b0011;
      end
      default: begin
        acc_span  = 3'd3;
        acc_lanes = 4'b1111;
      end
    endcase
    acc_be    = {4'b0000, acc_lanes} << req_addr[1:0];
    acc_data  = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    // 33-bit sum so an access running past 0xFFFFFFFF lands above LIMIT.
    acc_last  = {1'b0, req_addr} + {30'h0, acc_span};
    acc_err   = (acc_last >= LIMIT);
    acc_split = |acc_be[7:4];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = BEAT0;
      BEAT0:   state_next = (r_split && !r_err) ? BEAT1 : RESP;
      BEAT1:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE) && reset_n;
    resp_valid = (state == RESP);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_split <= 1'b0;
      r_off   <= 2'd0;
      r_be    <= 8'h00;
      r_data  <= 64'h0;
      r_rmask <= 32'h0;
      r_idx0  <= '0;
    end else if (accept) begin
      r_write <= req_write;
      r_err   <= acc_err;
      r_split <= acc_split;
      r_off   <= req_addr[1:0];
      r_be    <= acc_be;
      r_data  <= acc_data;
      r_rmask <= {{8{acc_lanes[3]}}, {8{acc_lanes[2]}}, {8{acc_lanes[1]}}, {8{acc_lanes[0]}}};
      r_idx0  <= req_addr[AW+1:2];
    end
  end

  assign r_idx1 = r_idx0 + AW'(1);

  assign mem_lo    = mem[r_idx0];
  assign mem_hi    = mem[r_idx1];
  assign rd_single = (mem_lo >> {r_off, 3'b000}) & r_rmask;
  assign rd_pair   = {mem_hi, cap_lo} >> {r_off, 3'b000};

  // Gating on reset_n keeps an aborted access from writing its second beat.
  assign mem_we0 = (state == BEAT0) && r_write && !r_err && reset_n;
  assign mem_we1 = (state == BEAT1) && r_write && reset_n;

  // NOTE: storage has no reset; its contents survive reset and it maps onto plain RAM.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we0) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) mem[r_idx0][8*b +: 8] <= r_data[8*b +: 8];
      end
    end
    if (mem_we1) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[4+b]) mem[r_idx1][8*b +: 8] <= r_data[32+8*b +: 8];
      end
    end
  end

  // Response registers update only on the edge into RESP and hold until the next one.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
      cap_lo     <= 32'h0;
    end else begin
      case (state)
        BEAT0: begin
          if (r_err) begin
            resp_rdata <= '0;
            resp_error <= 1'b1;
          end else if (!r_split) begin
            resp_rdata <= r_write ? 32'h0 : rd_single;
            resp_error <= 1'b0;
          end else begin
            cap_lo <= mem_lo;
          end
        end
        BEAT1: begin
          resp_rdata <= r_write ? 32'h0 : (rd_pair[31:0] & r_rmask);
          resp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed bench for mem_responder against a byte-array
// reference model of the memory, latency rules and response fields.
module tb_mem_responder;
  import isa_types::*;

  localparam int DEPTH = 256;
  localparam int BYTES = DEPTH * 4;

  logic         CLOCK_50 = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = 32'h0;
  logic [31:0]  req_wdata = 32'h0;
  write_width_t req_width = write_word;
  logic         req_ready;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         resp_error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [BYTES];

  mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_width (req_width),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input write_width_t w);
    case (w)
      write_byte: return 1;
      write_half: return 2;
      default:    return 4;
    endcase
  endfunction

  // One complete transaction; expectations come from the byte-array model.
  task automatic access(input bit w, input logic [31:0] a, input write_width_t wd,
                        input logic [31:0] d, input string tag,
                        output logic [31:0] rd, output logic er);
    int          n;
    int          lat;
    int          waited;
    int          exp_lat;
    bit          exp_err;
    bit          split;
    logic [31:0] exp_rd;
    n       = nbytes(wd);
    exp_err = (longint'(a) + longint'(n)) > longint'(BYTES);
    split   = (int'(a[1:0]) + n) > 4;
    exp_lat = (!exp_err && split) ? 3 : 2;
    exp_rd  = 32'h0;
    if (!exp_err) begin
      for (int k = 0; k < n; k++) begin
        if (w) ref_mem[int'(a) + k] = d[8*k +: 8];
        else   exp_rd[8*k +: 8] = ref_mem[int'(a) + k];
      end
    end
    @(negedge CLOCK_50);
    waited = 0;
    while (!req_ready && waited < 10) begin
      @(negedge CLOCK_50);
      waited++;
    end
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_width = wd;
    req_wdata = d;
    @(posedge CLOCK_50);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(posedge CLOCK_50);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, resp_rdata, exp_rd);
    check({tag, " error"}, 32'(resp_error), 32'(exp_err));
    rd = resp_rdata;
    er = resp_error;
    @(posedge CLOCK_50);
    #1;
    check({tag, " pulse"}, 32'(resp_valid), 32'd0);
    check({tag, " hold"}, resp_rdata, exp_rd);
  endtask

  initial begin
    logic [31:0]  rd;
    logic         er;
    logic [31:0]  a;
    logic [31:0]  d;
    write_width_t wd;
    bit           w;
    int           phase;
    int           accepts;
    int           pulses;
    bit           acc;
    logic [31:0]  hold_data [4];

    // Reset state
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst valid", 32'(resp_valid), 32'd0);
    check("rst rdata", resp_rdata, 32'h0);
    check("rst error", 32'(resp_error), 32'd0);
    reset_n = 1'b1;
    #1;
    check("post-rst ready", 32'(req_ready), 32'd1);

    // Fill storage so every later load has defined data
    for (int i = 0; i < DEPTH; i++) begin
      access(1'b1, 32'(i * 4), write_word, $urandom, "init", rd, er);
    end

    // Store word then load byte
    access(1'b1, 32'h10, write_word, 32'hDEADBEEF, "st_w10", rd, er);
    access(1'b0, 32'h11, write_byte, 32'h0, "ld_b11", rd, er);
    check("ld_b11 const", rd, 32'h000000BE);
    check("ld_b11 err const", 32'(er), 32'd0);

    // Split half store across words
    access(1'b1, 32'h23, write_half, 32'h0000A5C3, "st_h23", rd, er);
    access(1'b0, 32'h23, write_byte, 32'h0, "ld_b23", rd, er);
    check("ld_b23 const", rd, 32'h000000C3);
    access(1'b0, 32'h24, write_byte, 32'h0, "ld_b24", rd, er);
    check("ld_b24 const", rd, 32'h000000A5);
    access(1'b0, 32'h20, write_byte, 32'h0, "ld_b20", rd, er);
    access(1'b0, 32'h21, write_byte, 32'h0, "ld_b21", rd, er);
    access(1'b0, 32'h22, write_byte, 32'h0, "ld_b22", rd, er);
    access(1'b0, 32'h25, write_byte, 32'h0, "ld_b25", rd, er);

    // Out-of-range store and load
    access(1'b1, 32'h400, write_byte, 32'h0000005A, "st_b400", rd, er);
    check("st_b400 err const", 32'(er), 32'd1);
    access(1'b0, 32'h3FE, write_word, 32'h0, "ld_w3fe", rd, er);
    check("ld_w3fe err const", 32'(er), 32'd1);
    check("ld_w3fe rdata const", rd, 32'h0);
    access(1'b0, 32'h3FC, write_word, 32'h0, "ld_w3fc", rd, er);

    // Address wrap
    access(1'b0, 32'hFFFFFFFC, write_word, 32'h0, "ld_wrap", rd, er);
    check("ld_wrap err const", 32'(er), 32'd1);

    // Back-to-back stores with req_valid held high
    @(negedge CLOCK_50);
    phase   = 0;
    accepts = 0;
    pulses  = 0;
    for (int i = 0; i < 4; i++) hold_data[i] = $urandom;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_width = write_word;
    req_addr  = 32'h80;
    req_wdata = hold_data[0];
    for (int c = 0; c < 16; c++) begin
      check("hold ready", 32'(req_ready), 32'(phase == 0));
      check("hold valid", 32'(resp_valid), 32'(phase == 2));
      if (resp_valid) pulses++;
      acc = req_valid && req_ready;
      @(posedge CLOCK_50);
      if (acc) begin
        for (int k = 0; k < 4; k++) ref_mem[int'(req_addr) + k] = req_wdata[8*k +: 8];
        accepts++;
        phase = 1;
        #1;
        if (accepts == 4) begin
          req_valid = 1'b0;
        end else begin
          req_addr  = 32'h80 + 32'(accepts * 4);
          req_wdata = hold_data[accepts];
        end
      end else begin
        phase = (phase == 1) ? 2 : 0;
      end
      @(negedge CLOCK_50);
    end
    req_valid = 1'b0;
    check("hold accepts", 32'(accepts), 32'd4);
    check("hold pulses", 32'(pulses), 32'd4);
    for (int i = 0; i < 4; i++) begin
      access(1'b0, 32'h80 + 32'(i * 4), write_word, 32'h0, "hold readback", rd, er);
    end

    // Reset during the second beat of a split store
    access(1'b0, 32'h10, write_word, 32'h0, "pre-abort load", rd, er);
    @(negedge CLOCK_50);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h0E;
    req_width = write_word;
    req_wdata = 32'h11223344;
    @(posedge CLOCK_50);
    #1 req_valid = 1'b0;
    @(posedge CLOCK_50);
    #1 reset_n = 1'b0;
    ref_mem[32'h0E] = 8'h44;
    ref_mem[32'h0F] = 8'h33;
    #1;
    check("abort ready", 32'(req_ready), 32'd0);
    check("abort valid", 32'(resp_valid), 32'd0);
    check("abort rdata", resp_rdata, 32'h0);
    check("abort error", 32'(resp_error), 32'd0);
    repeat (2) begin
      @(negedge CLOCK_50);
      check("abort no resp", 32'(resp_valid), 32'd0);
    end
    reset_n = 1'b1;
    #1;
    check("release ready", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge CLOCK_50);
      check("release no resp", 32'(resp_valid), 32'd0);
    end
    access(1'b0, 32'h10, write_word, 32'h0, "post-abort w10", rd, er);
    access(1'b0, 32'h0E, write_half, 32'h0, "post-abort h0e", rd, er);
    check("post-abort h0e const", rd, 32'h00003344);

    // Random mix of loads and stores, including out-of-range and wrapping
    for (int i = 0; i < 120; i++) begin
      w  = 1'($urandom_range(0, 1));
      wd = write_width_t'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
      else                           a = 32'($urandom_range(0, BYTES + 4));
      d = $urandom;
      access(w, a, wd, d, "random", rd, er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
